// File: rtl/aes_key_sched_ctrl.sv
// aes_key_sched_ctrl: iterative AES-128 key expansion (one round per clock) with random-access round-key reads.
// Optional AES_KS_EQINV_EN stores equivalent-inverse-cipher keys (InvMixColumns on rk[1..9]) and zeroizes on load.
module aes_key_sched_ctrl #(
    parameter int NR     = 10,
    parameter bit RD_REG = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] key_in,
    input  logic         key_valid,
    output logic         key_ready,
    output logic         busy,
    output logic         keys_valid,
    input  logic         rd_en,
    input  logic [3:0]   rd_idx,
    output logic [127:0] rd_key,
    output logic         rd_valid,
    output logic         rd_err
);
    if (NR != 10) begin : g_nr_check
        $error("aes_key_sched_ctrl supports NR=10 only");
    end

    typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_e;

    state_e       state_q;
    logic [3:0]   cnt_q;
    logic         keys_valid_q;
    logic [127:0] rk_q [0:NR];
    logic         load, step;
    logic [127:0] src_d, raw_d, wr_d, rd_key_d;
    logic [31:0]  t_d, w0_d, w1_d, w2_d, w3_d;
    logic [7:0]   rcon_d;
    logic         rd_err_d;

    function automatic logic [7:0] gf_mul(logic [7:0] a, logic [7:0] b);
        logic [7:0] p, s;
        p = 8'h00;
        s = a;
        for (int i = 0; i < 8; i++) begin
            p = b[i] ? p ^ s : p;
            s = {s[6:0], 1'b0} ^ (s[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box as multiplicative inverse (x^254) followed by the affine map
    function automatic logic [7:0] sbox(logic [7:0] x);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 7; i >= 0; i--) begin
            r = gf_mul(r, r);
            r = (i != 0) ? gf_mul(r, x) : r;
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

`ifdef AES_KS_EQINV_EN
    logic [127:0] w_q;

    function automatic logic [31:0] inv_mix_col(logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
    endfunction
`endif

    assign load       = key_valid && state_q != EXPAND;
    assign step       = state_q == EXPAND;
    assign busy       = step;
    assign key_ready  = !step;
    assign keys_valid = keys_valid_q;

    always_comb begin
        rcon_d = cnt_q == 4'd9 ? 8'h1b : cnt_q == 4'd10 ? 8'h36 : 8'h01 << (cnt_q - 4'd1);
`ifdef AES_KS_EQINV_EN
        src_d = w_q;
`else
        src_d = rk_q[cnt_q - 4'd1];
`endif
        t_d  = {sbox(src_d[23:16]), sbox(src_d[15:8]), sbox(src_d[7:0]), sbox(src_d[31:24])} ^ {rcon_d, 24'h0};
        w0_d = src_d[127:96] ^ t_d;
        w1_d = src_d[95:64] ^ w0_d;
        w2_d = src_d[63:32] ^ w1_d;
        w3_d = src_d[31:0] ^ w2_d;
        raw_d = {w0_d, w1_d, w2_d, w3_d};
`ifdef AES_KS_EQINV_EN
        wr_d = cnt_q == 4'(NR) ? raw_d : {inv_mix_col(w0_d), inv_mix_col(w1_d), inv_mix_col(w2_d), inv_mix_col(w3_d)};
`else
        wr_d = raw_d;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            keys_valid_q <= 1'b0;
        end else if (load) begin
            state_q      <= EXPAND;
            cnt_q        <= 4'd1;
            keys_valid_q <= 1'b0;
        end else if (step) begin
            cnt_q        <= cnt_q == 4'(NR) ? cnt_q : cnt_q + 4'd1;
            state_q      <= cnt_q == 4'(NR) ? DONE : EXPAND;
            keys_valid_q <= cnt_q == 4'(NR);
        end
    end

    // Key store carries no reset; keys_valid gates every read of it
    always_ff @(posedge clk) begin
        if (load) begin
            rk_q[0] <= key_in;
`ifdef AES_KS_EQINV_EN
            for (int i = 1; i <= NR; i++) rk_q[i] <= '0;
`endif
        end else if (step) begin
            rk_q[cnt_q] <= wr_d;
        end
    end

`ifdef AES_KS_EQINV_EN
    always_ff @(posedge clk) begin
        if (load) w_q <= key_in;
        else if (step) w_q <= raw_d;
    end
`endif

    assign rd_err_d = rd_idx > 4'(NR) || !keys_valid_q;
    assign rd_key_d = rd_err_d ? '0 : rk_q[rd_idx];

    if (RD_REG) begin : g_rd_reg
        logic [127:0] rd_key_q;
        logic         rd_valid_q, rd_err_q;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rd_valid_q <= 1'b0;
                rd_err_q   <= 1'b0;
                rd_key_q   <= '0;
            end else begin
                rd_valid_q <= rd_en;
                if (rd_en) begin
                    rd_err_q <= rd_err_d;
                    rd_key_q <= rd_key_d;
                end
            end
        end
        assign rd_key   = rd_key_q;
        assign rd_valid = rd_valid_q;
        assign rd_err   = rd_err_q;
    end else begin : g_rd_comb
        assign rd_key   = rd_key_d;
        assign rd_valid = rd_en;
        assign rd_err   = rd_err_d;
    end
endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// tb_aes_key_sched_ctrl: directed checks of load, expansion timing, reads, hold-off, reset and reload.
// Expected round keys are the published FIPS-197 schedule values.
module tb_aes_key_sched_ctrl;
    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] key_in;
    logic         key_valid;
    logic         key_ready;
    logic         busy;
    logic         keys_valid;
    logic         rd_en;
    logic [3:0]   rd_idx;
    logic [127:0] rd_key;
    logic         rd_valid;
    logic         rd_err;
    int           n_checks = 0;
    int           n_fail = 0;

    localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY2      = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KEY2_RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    aes_key_sched_ctrl #(.NR(10), .RD_REG(1'b1)) dut (
        .clk(clk), .rst(rst), .key_in(key_in), .key_valid(key_valid), .key_ready(key_ready),
        .busy(busy), .keys_valid(keys_valid), .rd_en(rd_en), .rd_idx(rd_idx), .rd_key(rd_key),
        .rd_valid(rd_valid), .rd_err(rd_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [127:0] fips_rk(int i);
        case (i)
            0:  return 128'h2b7e151628aed2a6abf7158809cf4f3c;
            1:  return 128'ha0fafe1788542cb123a339392a6c7605;
            2:  return 128'hf2c295f27a96b9435935807a7359f67f;
            3:  return 128'h3d80477d4716fe3e1e237e446d7a883b;
            4:  return 128'hef44a541a8525b7fb671253bdb0bad00;
            5:  return 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
            6:  return 128'h6d88a37a110b3efddbf98641ca0093fd;
            7:  return 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
            8:  return 128'head27321b58dbad2312bf5607f8d292f;
            9:  return 128'hac7766f319fadc2128d12941575c006e;
            default: return 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        endcase
    endfunction

`ifdef AES_KS_EQINV_EN
    function automatic logic [7:0] xt(logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] tb_inv_mix(logic [127:0] k);
        logic [127:0] r;
        logic [7:0] a [4];
        logic [7:0] x2 [4], x4 [4], x8 [4];
        for (int c = 0; c < 4; c++) begin
            for (int j = 0; j < 4; j++) begin
                a[j]  = k[127 - 32*c - 8*j -: 8];
                x2[j] = xt(a[j]);
                x4[j] = xt(x2[j]);
                x8[j] = xt(x4[j]);
            end
            for (int j = 0; j < 4; j++)
                r[127 - 32*c - 8*j -: 8] = (x8[j] ^ x4[j] ^ x2[j]) ^ (x8[(j+1)%4] ^ x2[(j+1)%4] ^ a[(j+1)%4])
                                         ^ (x8[(j+2)%4] ^ x4[(j+2)%4] ^ a[(j+2)%4]) ^ (x8[(j+3)%4] ^ a[(j+3)%4]);
        end
        return r;
    endfunction
`endif

    function automatic logic [127:0] exp_rk(int i);
`ifdef AES_KS_EQINV_EN
        return (i >= 1 && i <= 9) ? tb_inv_mix(fips_rk(i)) : fips_rk(i);
`else
        return fips_rk(i);
`endif
    endfunction

    task automatic test_reset();
        n_checks++; if (key_ready !== 1'b1) begin n_fail++; $display("FAIL reset key_ready: got %b want 1", key_ready); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b want 0", busy); end
        n_checks++; if (keys_valid !== 1'b0) begin n_fail++; $display("FAIL reset keys_valid: got %b want 0", keys_valid); end
        n_checks++; if (rd_valid !== 1'b0 || rd_err !== 1'b0) begin n_fail++; $display("FAIL reset rd_valid/rd_err: got %b/%b want 0/0", rd_valid, rd_err); end
        n_checks++; if (rd_key !== 128'h0) begin n_fail++; $display("FAIL reset rd_key: got %h want 0", rd_key); end
    endtask

    task automatic test_load_fips();
        int busy_cnt = 0;
        int kv_early = 0;
        @(negedge clk);
        key_in = FIPS_KEY; key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (busy === 1'b1) busy_cnt++;
            if (keys_valid !== 1'b0) kv_early++;
            @(negedge clk);
        end
        n_checks++; if (busy_cnt !== 10) begin n_fail++; $display("FAIL load busy cycles: got %0d want 10", busy_cnt); end
        n_checks++; if (kv_early !== 0) begin n_fail++; $display("FAIL load keys_valid early: got %0d cycles high want 0", kv_early); end
        n_checks++; if (busy !== 1'b0 || keys_valid !== 1'b1 || key_ready !== 1'b1) begin n_fail++; $display("FAIL load done flags busy/kv/ready: got %b/%b/%b want 0/1/1", busy, keys_valid, key_ready); end
    endtask

    task automatic test_read_all();
        rd_en = 1'b1; rd_idx = 4'd10;
        for (int i = 10; i >= 0; i--) begin
            @(negedge clk);
            n_checks++; if (rd_valid !== 1'b1 || rd_err !== 1'b0) begin n_fail++; $display("FAIL read rk[%0d] valid/err: got %b/%b want 1/0", i, rd_valid, rd_err); end
            n_checks++; if (rd_key !== exp_rk(i)) begin n_fail++; $display("FAIL read rk[%0d]: got %h want %h", i, rd_key, exp_rk(i)); end
            if (i > 0) rd_idx = 4'(i - 1);
            else rd_en = 1'b0;
        end
        @(negedge clk);
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL read idle rd_valid: got %b want 0", rd_valid); end
        n_checks++; if (rd_key !== exp_rk(0)) begin n_fail++; $display("FAIL read idle rd_key hold: got %h want %h", rd_key, exp_rk(0)); end
        rd_en = 1'b1; rd_idx = 4'd11;
        @(negedge clk);
        rd_en = 1'b0;
        n_checks++; if (rd_valid !== 1'b1 || rd_err !== 1'b1 || rd_key !== 128'h0) begin n_fail++; $display("FAIL read idx11 valid/err/key: got %b/%b/%h want 1/1/0", rd_valid, rd_err, rd_key); end
    endtask

    task automatic test_hold_key();
        int ready_bad = 0;
        key_in = FIPS_KEY; key_valid = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            if (key_ready !== 1'b0) ready_bad++;
            if (i == 5) begin rd_en = 1'b1; rd_idx = 4'd0; end
            if (i == 6) begin
                rd_en = 1'b0;
                n_checks++; if (rd_valid !== 1'b1 || rd_err !== 1'b1 || rd_key !== 128'h0) begin n_fail++; $display("FAIL expand read valid/err/key: got %b/%b/%h want 1/1/0", rd_valid, rd_err, rd_key); end
            end
            @(negedge clk);
        end
        n_checks++; if (ready_bad !== 0) begin n_fail++; $display("FAIL expand key_ready high: got %0d cycles want 0", ready_bad); end
        n_checks++; if (key_ready !== 1'b1 || keys_valid !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL held key done ready/kv/busy: got %b/%b/%b want 1/1/0", key_ready, keys_valid, busy); end
        @(negedge clk);
        key_valid = 1'b0;
        n_checks++; if (busy !== 1'b1 || keys_valid !== 1'b0) begin n_fail++; $display("FAIL held key accept busy/kv: got %b/%b want 1/0", busy, keys_valid); end
        repeat (10) @(negedge clk);
        n_checks++; if (keys_valid !== 1'b1) begin n_fail++; $display("FAIL held key reexpand kv: got %b want 1", keys_valid); end
    endtask

    task automatic test_reset_mid();
        key_in = KEY2; key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        repeat (4) @(negedge clk);
        rd_en = 1'b1; rd_idx = 4'd11;
        @(negedge clk);
        rd_en = 1'b0;
        rst = 1'b1;
        #1;
        n_checks++; if (key_ready !== 1'b1 || busy !== 1'b0 || keys_valid !== 1'b0) begin n_fail++; $display("FAIL midreset ready/busy/kv: got %b/%b/%b want 1/0/0", key_ready, busy, keys_valid); end
        n_checks++; if (rd_valid !== 1'b0 || rd_err !== 1'b0 || rd_key !== 128'h0) begin n_fail++; $display("FAIL midreset rd valid/err/key: got %b/%b/%h want 0/0/0", rd_valid, rd_err, rd_key); end
        @(negedge clk);
        rst = 1'b0;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        repeat (10) @(negedge clk);
        n_checks++; if (keys_valid !== 1'b1) begin n_fail++; $display("FAIL key2 kv: got %b want 1", keys_valid); end
        rd_en = 1'b1; rd_idx = 4'd10;
        @(negedge clk);
        rd_idx = 4'd0;
        n_checks++; if (rd_key !== KEY2_RK10 || rd_err !== 1'b0) begin n_fail++; $display("FAIL key2 rk[10] key/err: got %h/%b want %h/0", rd_key, rd_err, KEY2_RK10); end
        @(negedge clk);
        rd_en = 1'b0;
        n_checks++; if (rd_key !== KEY2) begin n_fail++; $display("FAIL key2 rk[0]: got %h want %h", rd_key, KEY2); end
    endtask

    task automatic test_reload_read();
        int kv_bad = 0;
        key_in = FIPS_KEY; key_valid = 1'b1; rd_en = 1'b1; rd_idx = 4'd10;
        @(negedge clk);
        key_valid = 1'b0; rd_en = 1'b0;
        n_checks++; if (rd_valid !== 1'b1 || rd_err !== 1'b0 || rd_key !== KEY2_RK10) begin n_fail++; $display("FAIL reload read valid/err/key: got %b/%b/%h want 1/0/%h", rd_valid, rd_err, rd_key, KEY2_RK10); end
        n_checks++; if (keys_valid !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL reload kv/busy: got %b/%b want 0/1", keys_valid, busy); end
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (keys_valid !== 1'b0) kv_bad++;
        end
        n_checks++; if (kv_bad !== 0) begin n_fail++; $display("FAIL reload kv early: got %0d cycles high want 0", kv_bad); end
        @(negedge clk);
        n_checks++; if (keys_valid !== 1'b1) begin n_fail++; $display("FAIL reload kv at T10: got %b want 1", keys_valid); end
    endtask

    task automatic test_round_key_form();
        rd_en = 1'b1; rd_idx = 4'd1;
        @(negedge clk);
        rd_idx = 4'd10;
        n_checks++; if (rd_key !== exp_rk(1)) begin n_fail++; $display("FAIL form rk[1]: got %h want %h", rd_key, exp_rk(1)); end
        @(negedge clk);
        rd_idx = 4'd0;
        n_checks++; if (rd_key !== fips_rk(10)) begin n_fail++; $display("FAIL form rk[10]: got %h want %h", rd_key, fips_rk(10)); end
        @(negedge clk);
        rd_en = 1'b0;
        n_checks++; if (rd_key !== FIPS_KEY) begin n_fail++; $display("FAIL form rk[0]: got %h want %h", rd_key, FIPS_KEY); end
    endtask

    initial begin
        rst = 1'b1; key_in = '0; key_valid = 1'b0; rd_en = 1'b0; rd_idx = 4'd0;
        repeat (2) @(negedge clk);
        test_reset();
        rst = 1'b0;
        test_load_fips();
        test_read_all();
        test_hold_key();
        test_reset_mid();
        test_reload_read();
        test_round_key_form();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/aes_key_sched_ctrl.md
Name: aes_key_sched_ctrl

Overview:
Sequential AES-128 key-schedule controller. It accepts a cipher key, expands it one round per clock into an 11-entry round-key store, and serves random-access round-key reads to the decrypt datapath, which reads rk[10] down to rk[0]. It replaces the fully unrolled combinational key chain with a 10-cycle iterative expansion sharing one round-function instance.

Parameters:
NR, 10, number of rounds; only 10 is legal; elaboration error otherwise.
RD_REG, 1, 1 = read data registered (1-cycle latency); 0 = combinational read (0-cycle).

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
key_in  in  128  cipher key; MSB = byte 0.
key_valid  in  1  load request.
key_ready  out  1  controller can accept a key.
busy  out  1  expansion in progress.
keys_valid  out  1  all NR+1 round keys stored and consistent.
rd_en  in  1  read strobe.
rd_idx  in  4  round-key index 0..NR.
rd_key  out  128  round key.
rd_valid  out  1  rd_key/rd_err qualified.
rd_err  out  1  read rejected (idx > NR or keys not valid).

Behaviour:
- Reset (async, rst=1): state IDLE; round counter 0; key_ready=1, busy=0, keys_valid=0, rd_valid=0, rd_err=0, rd_key=0. The key store is not required to clear unless the optional feature is enabled.
- FSM states: IDLE, EXPAND, DONE.
- key_ready = (state != EXPAND). The handshake fires on a rising edge with key_valid & key_ready.
- On handshake at edge T0: rk[0] <= key_in; cnt <= 1; state <= EXPAND; keys_valid <= 0.
- EXPAND, each edge: rk[cnt] <= F(rk[cnt-1], rcon[cnt]); cnt <= cnt+1.
  - F is the standard AES-128 step: RotWord, SubWord, XOR rcon into the top byte of word 0, then cascaded XOR across words 1..3.
  - rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36.
- At the edge writing rk[10] (T10): state <= DONE; keys_valid <= 1. busy is high exactly for cycles T0+..T10.
- DONE: holds. A new handshake re-enters EXPAND exactly as from IDLE and drops keys_valid on that edge.
- key_valid while in EXPAND is ignored. There is no queuing; the requester must hold key_valid.
- Read, RD_REG=1: rd_en sampled at edge E.
  - At E: rd_valid <= 1; rd_err <= (rd_idx > NR) | ~keys_valid; rd_key <= rd_err ? 0 : rk[rd_idx].
  - Without rd_en: rd_valid <= 0 and rd_key holds.
  - Back-to-back reads give one result per cycle.
- Read, RD_REG=0: rd_valid = rd_en and rd_err is the same expression, both combinational.
- Simultaneous read and load handshake at the same edge: the read sees pre-edge keys_valid and store contents, so it succeeds if the old keys were valid.
- Reset mid-EXPAND: returns to IDLE immediately; keys_valid=0; a partial schedule is never exposed.
- cnt is 4 bits and never wraps past NR.

Optional Feature:
AES_KS_EQINV_EN
- Defined: each round key rk[1..9] is written through InvMixColumns as it is produced (equivalent inverse cipher keys). rk[0] and rk[10] are unchanged. The raw rk[i-1] used by the next step is kept in a separate 128-bit working register. Timing is unchanged.
- Additionally, while defined, a load handshake zeroes rk[1..10] on the same edge it loads rk[0].
- Undefined: raw FIPS-197 round keys are stored; no working register and no zeroize.

Test Plan:
- Load 2b7e151628aed2a6abf7158809cf4f3c -> busy high 10 cycles, keys_valid high after edge T10. Required values: rk[1]=a0fafe1788542cb123a339392a6c7605, rk[10]=d014f9a8c9ee2589e13f0cc8b6630ca6, rk[0]=key.
- Reads of rk[10]..rk[0] on consecutive cycles (RD_REG=1) -> results one cycle after each rd_en, in order, with rd_err=0. rd_idx=11 -> rd_valid=1, rd_err=1, rd_key=0.
- Read during EXPAND -> rd_err=1. key_valid held high during EXPAND -> not accepted (key_ready=0); accepted on the first cycle back in DONE.
- Assert rst at T5 of an expansion -> all outputs at reset values before the next edge. A later load of 000102030405060708090a0b0c0d0e0f -> rk[10]=13111d7fe3944a17f307a78b4d2b30c5.
- Reload in DONE with a read of rk[10] on the same edge -> the read returns the old rk[10] with rd_err=0; keys_valid is low from the next cycle until new T10.
- AES_KS_EQINV_EN defined, FIPS key -> rk[0] and rk[10] match raw values; rk[1] equals InvMixColumns(a0fafe17...) as computed by the reference model.
